// File: rtl/ultrasound_sweep_scheduler_pkg.sv
// Shared definitions for the ultrasound sweep scheduler: FSM state encodings,
// the "no reading" distance marker, sensor count limit and sensor-index width.
package ultrasound_pkg;

  localparam int         MAX_SENSORS = 6;
  localparam int         IDX_W       = 4;
  localparam logic [7:0] NO_READING  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_GUARD  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_STORE  = 3'd5,
    ST_REPORT = 3'd6
  } state_t;

endpackage

// File: rtl/ultrasound_sweep_scheduler_min_tracker.sv
// sweep_min_tracker: running unsigned minimum of the distances stored during a
// sweep, together with the sensor index that produced it. A clear restarts the
// search at NO_READING / index 0; strict less-than keeps the lower index on ties.
module sweep_min_tracker
  import ultrasound_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_update,
  input  logic [7:0]       i_value,
  input  logic [IDX_W-1:0] i_index,
  output logic [7:0]       o_min,
  output logic [IDX_W-1:0] o_index
);

  logic [7:0]       r_min;
  logic [IDX_W-1:0] r_index;

  // Clear has priority over update; only a strictly smaller value replaces the minimum.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_min   <= NO_READING;
      r_index <= '0;
    end else if (i_clear) begin
      r_min   <= NO_READING;
      r_index <= '0;
    end else if (i_update && (i_value < r_min)) begin
      r_min   <= i_value;
      r_index <= i_index;
    end
  end

  assign o_min   = r_min;
  assign o_index = r_index;

endmodule

// File: rtl/ultrasound_sweep_scheduler.sv
// ultrasound_sweep_scheduler: walks the median-filtered HCSR04 measurement
// block across the sensors selected by a mask, stores one distance per sensor
// in a small table, and reports the minimum distance and its sensor index.
// Optional build macro: ULTRASOUND_SWEEP_TIMEOUT_EN adds a per-sensor watchdog
// and the timeout_flags output; without it WAIT only exits on meas_done.
module ultrasound_sweep_scheduler
  import ultrasound_pkg::*;
#(
  parameter int          NUM_SENSORS    = 6,
  parameter int          GUARD_CYCLES   = 2,
  parameter logic [26:0] TIMEOUT_CYCLES = 27'd50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       continuous,
  input  logic [5:0] sensor_mask,
  input  logic       meas_done,
  input  logic [7:0] meas_distance,
  output logic       meas_enable,
  output logic [3:0] curr_ultrasound,
  input  logic [3:0] rd_index,
  output logic [7:0] rd_distance,
  output logic [7:0] min_distance,
  output logic [3:0] min_index,
  output logic [5:0] valid_mask,
  output logic       sweep_done,
  output logic       busy,
  output logic [2:0] state
`ifdef ULTRASOUND_SWEEP_TIMEOUT_EN
  ,
  output logic [5:0] timeout_flags
`endif
);

  if (NUM_SENSORS < 1 || NUM_SENSORS > MAX_SENSORS || GUARD_CYCLES > 255 ||
      TIMEOUT_CYCLES == 27'd0) begin : g_bad_cfg
    $error("ultrasound_sweep_scheduler: unsupported parameter set");
  end

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SENSORS);
  localparam logic [7:0]       GUARD_LOAD = 8'(GUARD_CYCLES);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_curr;
  logic [5:0]       r_mask;
  logic [5:0]       r_valid_work;
  logic [5:0]       r_valid_out;
  logic [7:0]       r_table [MAX_SENSORS];
  logic [7:0]       r_guard;
  logic [7:0]       r_sample;
  logic [7:0]       r_min_out;
  logic [IDX_W-1:0] r_min_idx_out;
  logic             w_hit;
  logic             w_tmo;
  logic             w_clear;
  logic             w_update;
  logic [7:0]       w_work_min;
  logic [IDX_W-1:0] w_work_idx;
  logic [7:0]       w_rd;

  // Mask bit of the sensor currently pointed to by idx.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < MAX_SENSORS; i++) begin
      if (r_idx == IDX_W'(i) && r_mask[i]) w_hit = 1'b1;
    end
  end

`ifdef ULTRASOUND_SWEEP_TIMEOUT_EN
  logic [26:0] r_tmo_cnt;
  logic [5:0]  r_tmo_flags;

  // A done arriving in the same cycle as the timeout takes precedence.
  assign w_tmo = (r_state == ST_WAIT) && !meas_done &&
                 (r_tmo_cnt >= (TIMEOUT_CYCLES - 27'd1));

  // Watchdog counts GUARD+WAIT cycles per sensor; flags are sticky for one sweep.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tmo_cnt   <= '0;
      r_tmo_flags <= '0;
    end else begin
      if (r_state == ST_LAUNCH) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ST_GUARD || r_state == ST_WAIT) && r_tmo_cnt != '1) begin
        r_tmo_cnt <= r_tmo_cnt + 27'd1;
      end
      if (w_clear) begin
        r_tmo_flags <= '0;
      end else if (w_tmo) begin
        for (int i = 0; i < MAX_SENSORS; i++) begin
          if (r_idx == IDX_W'(i)) r_tmo_flags[i] <= 1'b1;
        end
      end
    end
  end

  assign timeout_flags = r_tmo_flags;
`else
  assign w_tmo = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus the single-cycle pulses and tracker controls.
  always_comb begin
    w_next      = r_state;
    meas_enable = 1'b0;
    sweep_done  = 1'b0;
    w_clear     = 1'b0;
    w_update    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next  = ST_SELECT;
          w_clear = 1'b1;
        end
      end
      ST_SELECT: begin
        if (r_idx >= LAST_IDX) w_next = ST_REPORT;
        else if (w_hit)        w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        meas_enable = 1'b1;
        w_next      = ST_GUARD;
      end
      ST_GUARD: begin
        if (r_guard <= 8'd1) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (meas_done || w_tmo) w_next = ST_STORE;
      end
      ST_STORE: begin
        w_update = 1'b1;
        w_next   = ST_SELECT;
      end
      ST_REPORT: begin
        sweep_done = 1'b1;
        if (continuous) begin
          w_next  = ST_SELECT;
          w_clear = 1'b1;
        end else begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Sweep bookkeeping: index walk, sensor select, guard timer, table and result capture.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_idx         <= '0;
      r_curr        <= '0;
      r_mask        <= '0;
      r_valid_work  <= '0;
      r_valid_out   <= '0;
      r_guard       <= '0;
      r_sample      <= NO_READING;
      r_min_out     <= NO_READING;
      r_min_idx_out <= '0;
      for (int i = 0; i < MAX_SENSORS; i++) r_table[i] <= NO_READING;
    end else begin
      if (w_clear) begin
        r_idx        <= '0;
        r_valid_work <= '0;
      end
      if (r_state == ST_IDLE && start) r_mask <= sensor_mask;
      case (r_state)
        ST_SELECT: begin
          if (w_next == ST_LAUNCH)      r_curr <= r_idx;
          else if (w_next == ST_SELECT) r_idx  <= r_idx + 1'b1;
        end
        ST_LAUNCH: r_guard <= GUARD_LOAD;
        ST_GUARD: begin
          if (r_guard != 8'd0) r_guard <= r_guard - 8'd1;
        end
        ST_WAIT: begin
          if (meas_done) begin
            r_sample <= meas_distance;
            for (int i = 0; i < MAX_SENSORS; i++) begin
              if (r_idx == IDX_W'(i)) begin
                r_table[i]      <= meas_distance;
                r_valid_work[i] <= 1'b1;
              end
            end
          end else if (w_tmo) begin
            r_sample <= NO_READING;
            for (int i = 0; i < MAX_SENSORS; i++) begin
              if (r_idx == IDX_W'(i)) r_table[i] <= NO_READING;
            end
          end
        end
        ST_STORE: r_idx <= r_idx + 1'b1;
        ST_REPORT: begin
          r_min_out     <= w_work_min;
          r_min_idx_out <= w_work_idx;
          r_valid_out   <= r_valid_work;
        end
        default: ;
      endcase
    end
  end

  sweep_min_tracker u_min (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_clear),
    .i_update(w_update),
    .i_value (r_sample),
    .i_index (r_idx),
    .o_min   (w_work_min),
    .o_index (w_work_idx)
  );

  // Table read port; addresses past the last sensor read as NO_READING.
  always_comb begin
    w_rd = NO_READING;
    for (int i = 0; i < MAX_SENSORS; i++) begin
      if (rd_index == IDX_W'(i) && i < NUM_SENSORS) w_rd = r_table[i];
    end
  end

  assign rd_distance     = w_rd;
  assign curr_ultrasound = r_curr;
  assign min_distance    = r_min_out;
  assign min_index       = r_min_idx_out;
  assign valid_mask      = r_valid_out;
  assign busy            = (r_state != ST_IDLE);
  assign state           = r_state;

endmodule

// File: doc/ultrasound_sweep_scheduler.md
Name: ultrasound_sweep_scheduler

Overview:
Sequences the median-filtered ultrasound measurement block across up to 6 HCSR04 sensors. Each sweep visits the sensors selected by a mask, records one median distance per sensor, and reports the minimum distance and its sensor index. It sits between the top-level rover-tracking FSM and the measurement block, and owns that block's enable and sensor-select inputs.

Parameters:
NUM_SENSORS, 6, sensors scanned; index range 0..NUM_SENSORS-1, maximum 6
GUARD_CYCLES, 2, cycles after launch during which meas_done is ignored, so a stale done is not taken
TIMEOUT_CYCLES, 27'd50_000_000, per-sensor watchdog limit (1 s at 50 MHz); used only with the optional feature

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  level; sampled only in IDLE; starts one sweep
continuous  input  1  when 1, a new sweep begins automatically after REPORT
sensor_mask  input  6  bit i=1 includes sensor i; sampled at sweep start
meas_done  input  1  done level from the measurement block
meas_distance  input  8  median distance from the measurement block; valid while meas_done=1
meas_enable  output  1  one-cycle enable pulse to the measurement block
curr_ultrasound  output  4  sensor select to the measurement block
rd_index  input  4  read address into the distance table
rd_distance  output  8  combinational read of table[rd_index]; 8'hFF if rd_index>=NUM_SENSORS
min_distance  output  8  smallest distance stored in the last completed sweep
min_index  output  4  sensor that produced min_distance
valid_mask  output  6  bit i=1 means table[i] was written in the last sweep
sweep_done  output  1  one-cycle pulse when a sweep completes
busy  output  1  high in every state except IDLE
state  output  3  FSM state, exposed for debug

Behaviour:
- Reset (reset=0 at a clock edge) sets: state=IDLE, meas_enable=0, curr_ultrasound=0, all table entries=8'hFF, min_distance=8'hFF, min_index=0, valid_mask=0, sweep_done=0, busy=0. Reset mid-sweep aborts the sweep immediately and leaves no partial results.
- IDLE (0): if start=1, latch sensor_mask into active_mask, set idx=0, clear the working valid bits and working minimum (8'hFF), then go to SELECT.
- SELECT (1): if active_mask[idx]=1 or idx>=NUM_SENSORS, go to LAUNCH or REPORT respectively; otherwise increment idx and stay in SELECT. Skipping a sensor costs one cycle.
- LAUNCH (2): drive curr_ultrasound=idx and meas_enable=1 for exactly one cycle, load guard_cnt=GUARD_CYCLES, go to GUARD.
- GUARD (3): curr_ultrasound is held; decrement guard_cnt; at 0 go to WAIT.
- WAIT (4): when meas_done=1, write table[idx]=meas_distance, set working valid[idx]=1, then go to STORE.
- STORE (5): if the stored value is strictly less than the working minimum, update the minimum and its index. Ties keep the lower index. Then idx+1 and go to SELECT.
- REPORT (6): copy the working minimum, minimum index and valid bits to the outputs, pulse sweep_done for one cycle, then go to SELECT with idx=0 if continuous=1 (the mask is not resampled), else to IDLE.
- Empty mask: the sweep visits no sensors. REPORT leaves min_distance=8'hFF and valid_mask=0, and sweep_done still pulses. This takes NUM_SENSORS+2 cycles after start.
- Table entries are only written during a sweep. Entries for unmasked sensors keep their previous value, and valid_mask marks them stale.
- Latency per included sensor: 1 (SELECT) + 1 + GUARD_CYCLES + measurement time + 1 cycles.
- start is ignored while busy=1. Dropping continuous mid-sweep takes effect at the next REPORT.
- Distance compare is unsigned 8-bit.

Optional Feature:
ULTRASOUND_SWEEP_TIMEOUT_EN
- Defined: a 27-bit counter runs in GUARD and WAIT. On reaching TIMEOUT_CYCLES without meas_done, the FSM writes table[idx]=8'hFF and sets a sticky timeout_flag[idx] (extra 6-bit output timeout_flags, cleared at sweep start). valid[idx] stays 0 and the FSM proceeds to STORE. If meas_done and the timeout occur in the same cycle, meas_done wins.
- Undefined: WAIT has no exit except meas_done, there is no timeout_flags port and no counter is built.

Decomposition:
- Package ultrasound_pkg holds: the state encodings, NO_READING=8'hFF, MAX_SENSORS=6, and the sensor-index width (4).
- One sub-module, sweep_min_tracker: running unsigned minimum with index, clear/update/tie rule. Everything else stays inline.

Test Plan:
- Reset held low for 3 cycles in the middle of WAIT -> state=0, busy=0, valid_mask=0, min_distance=8'hFF, no meas_enable pulse afterwards.
- sensor_mask=6'b101101, model returns 40,25,90,25 for sensors 0,2,3,5 -> curr_ultrasound sequence 0,2,3,5, min_distance=25, min_index=2, valid_mask=6'b101101, one sweep_done pulse.
- Model holds meas_done=1 (stale) for 2 cycles after launch, with GUARD_CYCLES=2 -> no store during the guard; the new value 60 is stored only once the new done arrives.
- sensor_mask=0 with start -> sweep_done 8 cycles after start, min_distance=8'hFF, meas_enable never asserted.
- continuous=1 with mask 6'b000011 for 3 sweeps -> 3 sweep_done pulses, 6 meas_enable pulses, start ignored while busy.
- With ULTRASOUND_SWEEP_TIMEOUT_EN and TIMEOUT_CYCLES=100, sensor 1 never responds -> timeout_flags=6'b000010, rd_distance(1)=8'hFF, and the sweep completes.
